// File: rtl/lc_1313_decompress_rle.sv
// Run-length decoder: expands each (count, value) pair into `count` copies of `value`
// on an AXI-stream style output. The two-state FSM holds off new pairs while a run
// is being emitted; every output except in_tready comes straight from a flop.
module lc_1313_decompress_rle #(
  parameter int DATA_SIZE = 32,
  parameter int CNT_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_SIZE-1:0]  in_tfreq,
  input  logic [DATA_SIZE-1:0] in_tdata,
  input  logic                 in_tvalid,
  input  logic                 in_tlast,
  output logic                 in_tready,
  output logic [DATA_SIZE-1:0] out_tdata,
  output logic                 out_tvalid,
  output logic                 out_tlast,
  input  logic                 out_tready,
  output logic                 frame_done
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] val_q, val_d;
  logic [CNT_SIZE-1:0]  rem_q, rem_d;
  logic                 last_q, last_d;
  logic                 vld_q, vld_d;
  logic                 olast_q, olast_d;
  logic                 fdone_q, fdone_d;

  // Count values used to predict the final beat one cycle ahead, so out_tlast can be a flop.
  localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1);
  localparam logic [CNT_SIZE-1:0] CNT_TWO = CNT_SIZE'(2);

  // Ready is the only combinational output; it is forced low during reset.
  assign in_tready  = (state_q == IDLE) && !rst;
  assign out_tdata  = val_q;
  assign out_tvalid = vld_q;
  assign out_tlast  = olast_q;
  assign frame_done = fdone_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    rem_d   = rem_q;
    last_d  = last_q;
    vld_d   = vld_q;
    olast_d = olast_q;
    fdone_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_tvalid) begin
          if (in_tfreq != '0) begin
            state_d = EMIT;
            val_d   = in_tdata;
            rem_d   = in_tfreq;
            last_d  = in_tlast;
            vld_d   = 1'b1;
            olast_d = in_tlast && (in_tfreq == CNT_ONE);
          end else begin
            // Empty run: nothing to emit, but an empty final pair still closes the frame.
            fdone_d = in_tlast;
          end
        end
      end
      EMIT: begin
        if (vld_q && out_tready) begin
          if (rem_q == CNT_ONE) begin
            state_d = IDLE;
            rem_d   = '0;
            vld_d   = 1'b0;
            olast_d = 1'b0;
            fdone_d = last_q;
            last_d  = 1'b0;
          end else begin
            rem_d   = rem_q - CNT_ONE;
            olast_d = last_q && (rem_q == CNT_TWO);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any run in progress immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      olast_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      olast_q <= olast_d;
      fdone_q <= fdone_d;
    end
  end

endmodule

// File: tb/tb_lc_1313_decompress_rle.sv
// Scoreboard bench for the run-length decoder: the driver pushes expected beats when
// it offers a pair, a monitor pops and compares on each handshake.
module tb_lc_1313_decompress_rle;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] in_tfreq;
  logic [DW-1:0] in_tdata;
  logic          in_tvalid, in_tlast, in_tready;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid, out_tlast, out_tready, frame_done;

  lc_1313_decompress_rle #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
    .clk(clk), .rst(rst),
    .in_tfreq(in_tfreq), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
    .out_tready(out_tready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  beat_t exp_q[$];

  int passed = 0;
  int total  = 0;
  int beats  = 0;
  int fd_seen = 0;
  int fd_exp  = 0;
  logic tog_en = 1'b0;
  logic stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // out_tready driver: high, or a repeating stall pattern, changed just after each posedge.
  initial begin
    int idx = 0;
    logic [6:0] pat = 7'b1101001; // bit0 first: 1,0,0,1,0,1,1
    out_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tog_en) begin out_tready = pat[idx]; idx = (idx + 1) % 7; end
      else begin out_tready = 1'b1; idx = 0; end
    end
  end

  // Monitor: checks handshaked beats, stall stability, ready exclusivity, frame_done pulses.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) stall_prev = 1'b0;
      else begin
        if (stall_prev) begin
          check("stall_valid", 64'(out_tvalid), 64'd1);
          check("stall_data", 64'(out_tdata), 64'(prev_data));
          check("stall_last", 64'(out_tlast), 64'(prev_last));
        end
        stall_prev = out_tvalid && !out_tready;
        prev_data = out_tdata;
        prev_last = out_tlast;
        if (out_tvalid) check("ready_in_emit", 64'(in_tready), 64'd0);
        if (out_tvalid && out_tready) begin
          beats++;
          if (exp_q.size() == 0) check("unexpected_beat", 64'(out_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            check("beat_data", 64'(out_tdata), 64'(e.data));
            check("beat_last", 64'(out_tlast), 64'(e.last));
          end
        end
        if (frame_done) fd_seen++;
      end
    end
  end

  task automatic send(input int f, input logic [DW-1:0] d, input logic l);
    int n = 0;
    beat_t b;
    @(negedge clk);
    while (!in_tready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("send_timeout", 64'd0, 64'd1);
    in_tvalid = 1'b1; in_tfreq = CW'(f); in_tdata = d; in_tlast = l;
    for (int i = 0; i < f; i++) begin
      b.data = d; b.last = l && (i == f - 1);
      exp_q.push_back(b);
    end
    if (l) fd_exp++;
    @(posedge clk); #1;
    in_tvalid = 1'b0; in_tdata = '0; in_tfreq = '0; in_tlast = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_frame_done"}, 64'(fd_seen), 64'(fd_exp));
    check({name, "_ready_back"}, 64'(in_tready), 64'd1);
    check({name, "_valid_low"}, 64'(out_tvalid), 64'd0);
  endtask

  initial begin
    int start;
    in_tvalid = 1'b0; in_tfreq = '0; in_tdata = '0; in_tlast = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk); #2;
    check("rst_valid", 64'(out_tvalid), 64'd0);
    check("rst_data", 64'(out_tdata), 64'd0);
    check("rst_last", 64'(out_tlast), 64'd0);
    check("rst_fdone", 64'(frame_done), 64'd0);
    check("rst_ready", 64'(in_tready), 64'd0);
    @(negedge clk); rst = 1'b0; #1;
    check("post_rst_ready", 64'(in_tready), 64'd1);

    // Idle with garbage data and no valid: nothing should happen.
    in_tdata = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      check("idle_valid", 64'(out_tvalid), 64'd0);
      check("idle_fdone", 64'(frame_done), 64'd0);
    end
    in_tdata = '0;

    // Two runs, last pair closes the frame.
    send(2, 32'd7, 1'b0);
    send(3, 32'd9, 1'b1);
    drain("basic");

    // Back-pressure on a single run.
    tog_en = 1'b1;
    send(4, 32'hA5, 1'b0);
    drain("stall");
    tog_en = 1'b0;

    // Zero-count pairs.
    send(0, 32'd4, 1'b0);
    send(1, 32'd6, 1'b1);
    drain("zero_then_one");
    send(0, 32'd8, 1'b1);
    drain("zero_last");

    // Maximum count.
    start = beats;
    send(255, 32'h3C, 1'b1);
    drain("max_cnt");
    check("max_cnt_beats", 64'(beats - start), 64'd255);

    // Reset during a run.
    start = beats;
    send(5, 32'h11, 1'b0);
    fd_exp--; // no frame end expected for the aborted run (last=0 anyway, keep balance)
    fd_exp++;
    begin
      int n = 0;
      while (beats < start + 2 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("abort_wait_timeout", 64'd0, 64'd1);
    end
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check("abort_valid", 64'(out_tvalid), 64'd0);
    check("abort_last", 64'(out_tlast), 64'd0);
    check("abort_ready", 64'(in_tready), 64'd0);
    exp_q.delete();
    @(posedge clk); @(negedge clk);
    rst = 1'b0; #1;
    check("abort_ready_back", 64'(in_tready), 64'd1);
    send(1, 32'h22, 1'b1);
    drain("after_abort");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

endmodule
